vxe_cu_sync_ctrl: RTL and testbench

Control-unit sequencer for the VxE CU dispatch unit. It starts program execution, resumes the dispatcher after NOP/SYNC commands, and drains the dispatch FIFOs and both VPUs before completing a SYNC. It also turns SYNC-with-interrupt and fetch/decode faults into interrupt and fault status for the CU register block. It sits between the CU register block, the dispatch unit's control/fault outputs and the VPU busy indications.

---
 rtl/vxe_cu_sync_ctrl_if.sv | 34 +++
 rtl/vxe_cu_sync_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_vxe_cu_sync_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vxe_cu_sync_ctrl_if.sv
// Dispatcher-side control/fault handshake of the VxE CU sync sequencer.
// master: dispatch unit side; slave: vxe_cu_sync_ctrl.
interface vxe_cu_sync_ctrl_if;
    logic i_ctl_nop;
    logic i_ctl_sync;
    logic i_ctl_sync_stop;
    logic i_ctl_sync_intr;
    logic i_ctl_pipes_active;
    logic i_flt_fetch;
    logic i_flt_decode;
    logic o_ctl_unhalt;

    modport master (
        output i_ctl_nop,
        output i_ctl_sync,
        output i_ctl_sync_stop,
        output i_ctl_sync_intr,
        output i_ctl_pipes_active,
        output i_flt_fetch,
        output i_flt_decode,
        input  o_ctl_unhalt
    );

    modport slave (
        input  i_ctl_nop,
        input  i_ctl_sync,
        input  i_ctl_sync_stop,
        input  i_ctl_sync_intr,
        input  i_ctl_pipes_active,
        input  i_flt_fetch,
        input  i_flt_decode,
        output o_ctl_unhalt
    );
endinterface

// File: rtl/vxe_cu_sync_ctrl.sv
// VxE CU sequencer: start, NOP/SYNC resume, SYNC drain, interrupt and fault status.
// Optional drain watchdog enabled by defining VXE_CU_SYNC_WDOG_EN.
module vxe_cu_sync_ctrl #(
    parameter int unsigned WDOG_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic                  i_intr_ack,
    input  logic [1:0]            i_vpu_busy,
    output logic                  o_busy,
    output logic                  o_fetch_start,
    output logic                  o_intr,
    output logic                  o_fault,
    output logic [1:0]            o_fault_code,
    vxe_cu_sync_ctrl_if.slave     disp
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFault} state_e;

    localparam logic [1:0] CodeNone    = 2'b00;
    localparam logic [1:0] CodeFetch   = 2'b01;
    localparam logic [1:0] CodeDecode  = 2'b10;
    localparam logic [1:0] CodeTimeout = 2'b11;

    state_e     state_q, state_d;
    logic       stop_q, stop_d;
    logic       intr_f_q, intr_f_d;
    logic [1:0] idle_cnt_q, idle_cnt_d;
    logic       busy_q, busy_d;
    logic       fetch_q, fetch_d;
    logic       intr_q, intr_d;
    logic       fault_q, fault_d;
    logic [1:0] code_q, code_d;
    logic       unhalt_q, unhalt_d;

    logic       drain_idle;
    logic       intr_set;
    logic       fault_enter;
    logic [1:0] fault_code;
    logic       drain_done;
    logic       wdog_expire;

`ifdef VXE_CU_SYNC_WDOG_EN
    localparam logic [WDOG_WIDTH-1:0] WdogOne = {{(WDOG_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WDOG_WIDTH-1:0] WdogMax = '1;

    logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
    logic [WDOG_WIDTH-1:0] wdog_inc;

    assign wdog_inc    = wdog_q + WdogOne;
    assign wdog_expire = (wdog_inc == WdogMax);
`else
    // Width only matters when the watchdog is built in.
    logic unused_wdog_width;
    assign unused_wdog_width = (WDOG_WIDTH != 0);
    assign wdog_expire       = 1'b0;
`endif

    assign drain_idle = !disp.i_ctl_pipes_active && (i_vpu_busy == 2'b00);

    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        intr_f_d    = intr_f_q;
        idle_cnt_d  = idle_cnt_q;
        fault_d     = fault_q;
        code_d      = code_q;
        fetch_d     = 1'b0;
        unhalt_d    = 1'b0;
        intr_set    = 1'b0;
        fault_enter = 1'b0;
        fault_code  = CodeNone;
        drain_done  = 1'b0;
`ifdef VXE_CU_SYNC_WDOG_EN
        wdog_d      = wdog_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StRun;
                    unhalt_d = 1'b1;
                    fetch_d  = 1'b1;
                end
            end

            StRun: begin
                if (disp.i_flt_decode) begin
                    fault_enter = 1'b1;
                    fault_code  = CodeDecode;
                end else if (disp.i_flt_fetch) begin
                    fault_enter = 1'b1;
                    fault_code  = CodeFetch;
                end else if (disp.i_ctl_sync) begin
                    state_d    = StDrain;
                    stop_d     = disp.i_ctl_sync_stop;
                    intr_f_d   = disp.i_ctl_sync_intr;
                    idle_cnt_d = 2'd0;
`ifdef VXE_CU_SYNC_WDOG_EN
                    wdog_d     = '0;
`endif
                end else if (disp.i_ctl_nop) begin
                    unhalt_d = 1'b1;
                end
            end

            StDrain: begin
                if (disp.i_flt_decode) begin
                    fault_enter = 1'b1;
                    fault_code  = CodeDecode;
                end else if (disp.i_flt_fetch) begin
                    fault_enter = 1'b1;
                    fault_code  = CodeFetch;
                end else begin
`ifdef VXE_CU_SYNC_WDOG_EN
                    wdog_d = wdog_inc;
`endif
                    // Completion needs two back-to-back idle cycles.
                    if (drain_idle) begin
                        if (idle_cnt_q == 2'd1) begin
                            drain_done = 1'b1;
                            idle_cnt_d = 2'd0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 2'd1;
                        end
                    end else begin
                        idle_cnt_d = 2'd0;
                    end

                    if (drain_done) begin
                        intr_set = intr_f_q;
                        if (stop_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d  = StRun;
                            unhalt_d = 1'b1;
                        end
                    end else if (wdog_expire) begin
                        fault_enter = 1'b1;
                        fault_code  = CodeTimeout;
                    end
                end
            end

            StFault: begin
                if (i_start) begin
                    state_d  = StRun;
                    fault_d  = 1'b0;
                    code_d   = CodeNone;
                    unhalt_d = 1'b1;
                    fetch_d  = 1'b1;
                end
            end
        endcase

        if (fault_enter) begin
            state_d  = StFault;
            fault_d  = 1'b1;
            code_d   = fault_code;
            intr_set = 1'b1;
        end

        // A new interrupt beats an acknowledge landing in the same cycle.
        if (intr_set) begin
            intr_d = 1'b1;
        end else if (i_intr_ack) begin
            intr_d = 1'b0;
        end else begin
            intr_d = intr_q;
        end

        busy_d = (state_d == StRun) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            stop_q     <= 1'b0;
            intr_f_q   <= 1'b0;
            idle_cnt_q <= 2'd0;
            busy_q     <= 1'b0;
            fetch_q    <= 1'b0;
            intr_q     <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= CodeNone;
            unhalt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            intr_f_q   <= intr_f_d;
            idle_cnt_q <= idle_cnt_d;
            busy_q     <= busy_d;
            fetch_q    <= fetch_d;
            intr_q     <= intr_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            unhalt_q   <= unhalt_d;
        end
    end

`ifdef VXE_CU_SYNC_WDOG_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign o_busy            = busy_q;
    assign o_fetch_start     = fetch_q;
    assign o_intr            = intr_q;
    assign o_fault           = fault_q;
    assign o_fault_code      = code_q;
    assign disp.o_ctl_unhalt = unhalt_q;

endmodule

// File: tb/tb_vxe_cu_sync_ctrl.sv
// Self-checking bench for vxe_cu_sync_ctrl: per-cycle behavioural model plus directed literals.
module tb_vxe_cu_sync_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_intr_ack = 1'b0;
    logic [1:0] i_vpu_busy = 2'b00;
    logic       o_busy, o_fetch_start, o_intr, o_fault;
    logic [1:0] o_fault_code;

    int n_checks = 0;
    int n_fail = 0;

    vxe_cu_sync_ctrl_if disp_if ();

    vxe_cu_sync_ctrl #(
        .WDOG_WIDTH (4)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_start       (i_start),
        .i_intr_ack    (i_intr_ack),
        .i_vpu_busy    (i_vpu_busy),
        .o_busy        (o_busy),
        .o_fetch_start (o_fetch_start),
        .o_intr        (o_intr),
        .o_fault       (o_fault),
        .o_fault_code  (o_fault_code),
        .disp          (disp_if)
    );

    always #5 clk = ~clk;

`ifdef VXE_CU_SYNC_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif
    localparam int WdLimit = 15;

    localparam logic [1:0] MIdle  = 2'd0;
    localparam logic [1:0] MRun   = 2'd1;
    localparam logic [1:0] MDrain = 2'd2;
    localparam logic [1:0] MFault = 2'd3;

    typedef struct packed {
        logic [1:0]  mode;
        logic        stop;
        logic        intr_f;
        logic [7:0]  streak;
        logic [31:0] dcyc;
        logic        busy;
        logic        fetch;
        logic        intr;
        logic        fault;
        logic [1:0]  code;
        logic        unhalt;
    } model_t;

    model_t m = '0;

    function automatic model_t next_model(model_t c);
        model_t     n;
        logic [1:0] fc;
        logic       raised;
        n        = c;
        n.fetch  = 1'b0;
        n.unhalt = 1'b0;
        raised   = 1'b0;
        fc = disp_if.i_flt_decode ? 2'b10 : (disp_if.i_flt_fetch ? 2'b01 : 2'b00);
        if (c.mode == MIdle) begin
            if (i_start) begin
                n.mode = MRun; n.unhalt = 1'b1; n.fetch = 1'b1;
            end
        end else if (c.mode == MFault) begin
            if (i_start) begin
                n.mode = MRun; n.fault = 1'b0; n.code = 2'b00;
                n.unhalt = 1'b1; n.fetch = 1'b1;
            end
        end else if (fc != 2'b00) begin
            n.mode = MFault; n.fault = 1'b1; n.code = fc; raised = 1'b1;
        end else if (c.mode == MRun) begin
            if (disp_if.i_ctl_sync) begin
                n.mode   = MDrain;
                n.stop   = disp_if.i_ctl_sync_stop;
                n.intr_f = disp_if.i_ctl_sync_intr;
                n.streak = 0;
                n.dcyc   = 0;
            end else if (disp_if.i_ctl_nop) begin
                n.unhalt = 1'b1;
            end
        end else begin
            n.dcyc   = c.dcyc + 1;
            n.streak = (!disp_if.i_ctl_pipes_active && i_vpu_busy == 2'b00) ? c.streak + 1 : 0;
            if (n.streak == 2) begin
                if (c.intr_f) raised = 1'b1;
                if (c.stop) n.mode = MIdle;
                else begin
                    n.mode = MRun; n.unhalt = 1'b1;
                end
            end else if (WdogOn && n.dcyc == WdLimit) begin
                n.mode = MFault; n.fault = 1'b1; n.code = 2'b11; raised = 1'b1;
            end
        end
        if (raised) n.intr = 1'b1;
        else if (i_intr_ack) n.intr = 1'b0;
        n.busy = (n.mode == MRun) || (n.mode == MDrain);
        return n;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) m <= '0;
        else m <= next_model(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model busy", 32'(o_busy), 32'(m.busy));
        chk("model fetch_start", 32'(o_fetch_start), 32'(m.fetch));
        chk("model intr", 32'(o_intr), 32'(m.intr));
        chk("model fault", 32'(o_fault), 32'(m.fault));
        chk("model fault_code", 32'(o_fault_code), 32'(m.code));
        chk("model unhalt", 32'(disp_if.o_ctl_unhalt), 32'(m.unhalt));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " fetch"}, 32'(o_fetch_start), 0);
        chk({tag, " intr"}, 32'(o_intr), 0);
        chk({tag, " fault"}, 32'(o_fault), 0);
        chk({tag, " code"}, 32'(o_fault_code), 0);
        chk({tag, " unhalt"}, 32'(disp_if.o_ctl_unhalt), 0);
    endtask

    initial begin
        disp_if.i_ctl_nop          = 1'b0;
        disp_if.i_ctl_sync         = 1'b0;
        disp_if.i_ctl_sync_stop    = 1'b0;
        disp_if.i_ctl_sync_intr    = 1'b0;
        disp_if.i_ctl_pipes_active = 1'b0;
        disp_if.i_flt_fetch        = 1'b0;
        disp_if.i_flt_decode       = 1'b0;

        repeat (3) step();
        chk_reset_outputs("reset");
        nrst = 1'b1;
        step();

        // Start, then NOP.
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("start unhalt", 32'(disp_if.o_ctl_unhalt), 1);
        chk("start fetch", 32'(o_fetch_start), 1);
        chk("start busy", 32'(o_busy), 1);
        step();
        chk("start unhalt width", 32'(disp_if.o_ctl_unhalt), 0);
        chk("start fetch width", 32'(o_fetch_start), 0);
        disp_if.i_ctl_nop = 1'b1; step(); disp_if.i_ctl_nop = 1'b0;
        chk("nop unhalt", 32'(disp_if.o_ctl_unhalt), 1);
        step();
        chk("nop busy", 32'(o_busy), 1);

        // SYNC with interrupt, VPU0 busy for 5 cycles.
        disp_if.i_ctl_sync = 1'b1; disp_if.i_ctl_sync_intr = 1'b1; i_vpu_busy = 2'b01;
        step();
        disp_if.i_ctl_sync = 1'b0; disp_if.i_ctl_sync_intr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sync busy no unhalt", 32'(disp_if.o_ctl_unhalt), 0);
        end
        i_vpu_busy = 2'b00;
        step();
        chk("sync first idle unhalt", 32'(disp_if.o_ctl_unhalt), 0);
        chk("sync first idle intr", 32'(o_intr), 0);
        step();
        chk("sync done unhalt", 32'(disp_if.o_ctl_unhalt), 1);
        chk("sync done intr", 32'(o_intr), 1);
        step();
        i_intr_ack = 1'b1; step(); i_intr_ack = 1'b0;
        chk("intr ack", 32'(o_intr), 0);

        // SYNC with stop.
        disp_if.i_ctl_sync = 1'b1; disp_if.i_ctl_sync_stop = 1'b1;
        step();
        disp_if.i_ctl_sync = 1'b0; disp_if.i_ctl_sync_stop = 1'b0;
        step();
        step();
        chk("stop busy", 32'(o_busy), 0);
        chk("stop unhalt", 32'(disp_if.o_ctl_unhalt), 0);
        step();
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("restart unhalt", 32'(disp_if.o_ctl_unhalt), 1);
        chk("restart fetch", 32'(o_fetch_start), 1);

        // Simultaneous fetch and decode faults: decode wins.
        disp_if.i_flt_fetch = 1'b1; disp_if.i_flt_decode = 1'b1;
        step();
        disp_if.i_flt_fetch = 1'b0; disp_if.i_flt_decode = 1'b0;
        chk("fault flag", 32'(o_fault), 1);
        chk("fault code", 32'(o_fault_code), 2);
        chk("fault intr", 32'(o_intr), 1);
        chk("fault busy", 32'(o_busy), 0);
        disp_if.i_flt_fetch = 1'b1; step(); disp_if.i_flt_fetch = 1'b0;
        chk("fault no relatch", 32'(o_fault_code), 2);
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("fault clear", 32'(o_fault), 0);
        chk("fault clear code", 32'(o_fault_code), 0);
        chk("fault clear busy", 32'(o_busy), 1);
        i_intr_ack = 1'b1; step(); i_intr_ack = 1'b0;

        // Idle, busy, idle, idle.
        disp_if.i_ctl_sync = 1'b1; disp_if.i_ctl_pipes_active = 1'b1;
        step();
        disp_if.i_ctl_sync = 1'b0;
        step();
        disp_if.i_ctl_pipes_active = 1'b0; step();
        chk("glitch idle1", 32'(disp_if.o_ctl_unhalt), 0);
        disp_if.i_ctl_pipes_active = 1'b1; step();
        chk("glitch busy", 32'(disp_if.o_ctl_unhalt), 0);
        disp_if.i_ctl_pipes_active = 1'b0; step();
        chk("glitch idle2", 32'(disp_if.o_ctl_unhalt), 0);
        step();
        chk("glitch done", 32'(disp_if.o_ctl_unhalt), 1);
        chk("glitch busy out", 32'(o_busy), 1);

        // Reset in the middle of a drain.
        disp_if.i_ctl_sync = 1'b1; disp_if.i_ctl_sync_intr = 1'b1; disp_if.i_ctl_pipes_active = 1'b1;
        step();
        disp_if.i_ctl_sync = 1'b0; disp_if.i_ctl_sync_intr = 1'b0;
        step();
        nrst = 1'b0;
        #1;
        chk_reset_outputs("mid-drain reset");
        step();
        nrst = 1'b1;
        disp_if.i_ctl_pipes_active = 1'b0;
        step();

        // Watchdog with pipes held active.
        i_start = 1'b1; step(); i_start = 1'b0;
        disp_if.i_ctl_sync = 1'b1; disp_if.i_ctl_pipes_active = 1'b1;
        step();
        disp_if.i_ctl_sync = 1'b0;
        repeat (14) step();
        chk("wdog before limit", 32'(o_fault), 0);
        step();
`ifdef VXE_CU_SYNC_WDOG_EN
        chk("wdog fault", 32'(o_fault), 1);
        chk("wdog code", 32'(o_fault_code), 3);
        chk("wdog intr", 32'(o_intr), 1);
        chk("wdog no unhalt", 32'(disp_if.o_ctl_unhalt), 0);
`else
        chk("no wdog busy", 32'(o_busy), 1);
        repeat (85) step();
        chk("no wdog still drain", 32'(o_busy), 1);
        chk("no wdog no fault", 32'(o_fault), 0);
`endif
        disp_if.i_ctl_pipes_active = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
